// File: rtl/voice_timer_pkg.sv
// Shared types and constants for the voice-path interval timer.
// Holds the FSM state encoding and the sizing defaults used by the timer and its prescaler.
package voice_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  localparam int             CNT_W_DEF    = 16;
  localparam int             PS_W         = 16;
  localparam logic [PS_W-1:0] PRESCALE_MIN = 16'd2;

endpackage

// File: rtl/voice_timer_ctrl_if.sv
// Command/status bundle between a timer client and voice_timer_ctrl.
// The client drives the i_* commands and observes the registered o_* status.
interface voice_timer_ctrl_if
  import voice_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             i_start;
  logic             i_stop;
  logic             i_clear;
  logic [CNT_W-1:0] i_target;
  logic             i_auto_reload;
  logic [CNT_W-1:0] o_count;
  logic             o_tick;
  logic             o_expire;
  logic             o_busy;
  logic [1:0]       o_state;

  modport master (
    output i_start, i_stop, i_clear, i_target, i_auto_reload,
    input  o_count, o_tick, o_expire, o_busy, o_state
  );

  modport slave (
    input  i_start, i_stop, i_clear, i_target, i_auto_reload,
    output o_count, o_tick, o_expire, o_busy, o_state
  );

endinterface

// File: rtl/voice_tick_prescaler.sv
// Clock-to-tick divider: counts 0..PRESCALE-1 while enabled, holds otherwise.
// o_tick flags the terminal count; the owner decides whether that cycle really ticks.
module voice_tick_prescaler
  import voice_timer_pkg::*;
#(
  parameter logic [PS_W-1:0] PRESCALE = 16'd1000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [PS_W-1:0] PS_LAST = PRESCALE - 16'd1;
  localparam logic [PS_W-1:0] PS_ONE  = 16'd1;

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  assign o_tick = (ps_q == PS_LAST);

  always_comb begin
    ps_d = ps_q;
    if (i_clr) begin
      ps_d = '0;
    end else if (i_en) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_ONE;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/voice_timer_ctrl.sv
// Tick-based interval timer: start/pause/resume/clear sequencing of a tick counter
// with one-shot or auto-reload expiry. All status outputs are registered.
module voice_timer_ctrl
  import voice_timer_pkg::*;
#(
  parameter logic [PS_W-1:0] PRESCALE = 16'd1000,
  parameter int              CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  voice_timer_ctrl_if.slave  bus
);

  // Out-of-range prescale values are clamped so the divider always has a real period.
  localparam logic [PS_W-1:0]  PS_EFF  = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN : PRESCALE;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             expire_q, expire_d;
  logic             busy_q, busy_d;
  logic             ps_en, ps_clr, ps_last;

  voice_tick_prescaler #(
    .PRESCALE (PS_EFF)
  ) u_prescaler (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (ps_en),
    .i_clr   (ps_clr),
    .o_tick  (ps_last)
  );

  // Commands are decoded strictly by priority clear > stop > start; the prescaler
  // only advances on RUN cycles that carry no stop/clear, which keeps phase across pauses.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    expire_d = 1'b0;
    ps_en    = 1'b0;
    ps_clr   = 1'b0;

    if (bus.i_clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      ps_clr  = 1'b1;
    end else if (bus.i_stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else if (state_q == ST_PAUSE) begin
        state_d = ST_IDLE;
        count_d = '0;
        ps_clr  = 1'b1;
      end
    end else if (bus.i_start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      if (state_q != ST_PAUSE) begin
        count_d  = '0;
        target_d = bus.i_target;
        reload_d = bus.i_auto_reload;
        ps_clr   = 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      ps_en = 1'b1;
      if (ps_last) begin
        tick_d = 1'b1;
        // A zero target never matches, so the counter free-runs and wraps.
        if ((target_q != '0) && (count_q == target_q - CNT_ONE)) begin
          expire_d = 1'b1;
          if (reload_q) begin
            count_d = '0;
          end else begin
            count_d = target_q;
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      target_q <= '0;
      reload_q <= 1'b0;
      tick_q   <= 1'b0;
      expire_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      expire_q <= expire_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_count  = count_q;
  assign bus.o_tick   = tick_q;
  assign bus.o_expire = expire_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_state  = state_q;

endmodule

// File: tb/tb_voice_timer_ctrl.sv
// Directed bench for voice_timer_ctrl: PRESCALE=4 main instance plus a narrow
// PRESCALE=2 instance used to reach the free-run counter wrap quickly.
module tb_voice_timer_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  voice_timer_ctrl_if #(.CNT_W(16)) bus_a ();
  voice_timer_ctrl_if #(.CNT_W(8))  bus_b ();

  voice_timer_ctrl #(.PRESCALE(16'd4), .CNT_W(16)) dut_a (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  voice_timer_ctrl #(.PRESCALE(16'd2), .CNT_W(8)) dut_b (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {tick, expire, busy, state[1:0], count[15:0]}
  function automatic logic [20:0] obs_a();
    return {bus_a.o_tick, bus_a.o_expire, bus_a.o_busy, bus_a.o_state, bus_a.o_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus_a.i_clear = 1'b1;
    bus_b.i_clear = 1'b1;
    step();
    bus_a.i_clear = 1'b0;
    bus_b.i_clear = 1'b0;
  endtask

  // Drives start during cycle 0 and returns positioned in cycle 1.
  task automatic start_a(input logic [15:0] tgt, input logic ar);
    bus_a.i_target      = tgt;
    bus_a.i_auto_reload = ar;
    bus_a.i_start       = 1'b1;
    step();
    bus_a.i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if (obs_a() !== 21'h0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", obs_a());
    end
    checks++;
    if ({bus_b.o_tick, bus_b.o_expire, bus_b.o_busy, bus_b.o_state, bus_b.o_count} !== 13'h0) begin
      errors++;
      $display("FAIL reset_b got %h want 0",
               {bus_b.o_tick, bus_b.o_expire, bus_b.o_busy, bus_b.o_state, bus_b.o_count});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    logic [20:0] e;
    logic [15:0] ec;
    do_clear();
    start_a(16'd3, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      ec = (c < 5) ? 16'd0 : (c < 9) ? 16'd1 : (c < 13) ? 16'd2 : 16'd3;
      e  = {(c == 5 || c == 9 || c == 13), (c == 13), (c < 13),
            ((c < 13) ? 2'd1 : 2'd3), ec};
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL one_shot cycle %0d got %h want %h", c, obs_a(), e);
      end
      step();
    end
  endtask

  task automatic test_auto_reload();
    logic [20:0] e;
    logic [15:0] ec;
    do_clear();
    start_a(16'd2, 1'b1);
    for (int c = 1; c <= 19; c++) begin
      ec = (c < 5) ? 16'd0 : (c < 9) ? 16'd1 : (c < 13) ? 16'd0 : (c < 17) ? 16'd1 : 16'd0;
      e  = {(c == 5 || c == 9 || c == 13 || c == 17), (c == 9 || c == 17), 1'b1, 2'd1, ec};
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL auto_reload cycle %0d got %h want %h", c, obs_a(), e);
      end
      step();
    end
  endtask

  task automatic test_pause_resume();
    logic [20:0] e;
    logic [15:0] ec;
    logic        run;
    do_clear();
    start_a(16'd5, 1'b0);
    for (int c = 1; c <= 26; c++) begin
      run = (c <= 6) || (c >= 21);
      ec  = (c < 5) ? 16'd0 : (c < 24) ? 16'd1 : 16'd2;
      e   = {(c == 5 || c == 24), 1'b0, run, (run ? 2'd1 : 2'd2), ec};
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL pause_resume cycle %0d got %h want %h", c, obs_a(), e);
      end
      bus_a.i_stop  = (c == 6);
      bus_a.i_start = (c == 20);
      step();
    end
    bus_a.i_stop  = 1'b0;
    bus_a.i_start = 1'b0;
  endtask

  task automatic test_priority();
    do_clear();
    start_a(16'd5, 1'b0);
    repeat (5) step();
    bus_a.i_clear = 1'b1;
    bus_a.i_start = 1'b1;
    step();
    bus_a.i_clear = 1'b0;
    bus_a.i_start = 1'b0;
    checks++;
    if (obs_a() !== 21'h0) begin
      errors++;
      $display("FAIL clear_over_start got %h want 0", obs_a());
    end

    start_a(16'd2, 1'b0);
    repeat (7) step();
    checks++;
    if (obs_a() !== {3'b001, 2'd1, 16'd1}) begin
      errors++;
      $display("FAIL pre_stop cycle8 got %h want %h", obs_a(), {3'b001, 2'd1, 16'd1});
    end
    bus_a.i_stop = 1'b1;
    step();
    bus_a.i_stop = 1'b0;
    checks++;
    if (obs_a() !== {3'b000, 2'd2, 16'd1}) begin
      errors++;
      $display("FAIL stop_on_expiry got %h want %h", obs_a(), {3'b000, 2'd2, 16'd1});
    end
    repeat (3) step();
    checks++;
    if (obs_a() !== {3'b000, 2'd2, 16'd1}) begin
      errors++;
      $display("FAIL pause_hold got %h want %h", obs_a(), {3'b000, 2'd2, 16'd1});
    end
    bus_a.i_start = 1'b1;
    step();
    bus_a.i_start = 1'b0;
    checks++;
    if (obs_a() !== {3'b001, 2'd1, 16'd1}) begin
      errors++;
      $display("FAIL resume got %h want %h", obs_a(), {3'b001, 2'd1, 16'd1});
    end
    step();
    checks++;
    if (obs_a() !== {3'b110, 2'd3, 16'd2}) begin
      errors++;
      $display("FAIL resume_expire got %h want %h", obs_a(), {3'b110, 2'd3, 16'd2});
    end
    bus_a.i_stop = 1'b1;
    step();
    bus_a.i_stop = 1'b0;
    checks++;
    if (obs_a() !== {3'b000, 2'd3, 16'd2}) begin
      errors++;
      $display("FAIL stop_in_done got %h want %h", obs_a(), {3'b000, 2'd3, 16'd2});
    end
  endtask

  task automatic test_free_run_wrap();
    int expires;
    expires = 0;
    do_clear();
    bus_b.i_target      = 8'd0;
    bus_b.i_auto_reload = 1'b0;
    bus_b.i_start       = 1'b1;
    step();
    bus_b.i_start = 1'b0;
    for (int c = 1; c <= 520; c++) begin
      if (bus_b.o_expire) expires++;
      if (c == 511 || c == 512 || c == 513) begin
        checks++;
        if ({bus_b.o_tick, bus_b.o_count} !== ((c == 513) ? 9'h100 : (c == 511) ? 9'h1FF : 9'h0FF)) begin
          errors++;
          $display("FAIL wrap cycle %0d got tick=%0b count=%h", c, bus_b.o_tick, bus_b.o_count);
        end
      end
      step();
    end
    checks++;
    if (expires !== 0 || bus_b.o_state !== 2'd1) begin
      errors++;
      $display("FAIL wrap_no_expire got expires=%0d state=%0d want 0 and 1", expires, bus_b.o_state);
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    start_a(16'd3, 1'b0);
    repeat (9) step();
    checks++;
    if (obs_a() !== {3'b001, 2'd1, 16'd2}) begin
      errors++;
      $display("FAIL pre_reset cycle10 got %h want %h", obs_a(), {3'b001, 2'd1, 16'd2});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 21'h0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", obs_a());
    end
    step();
    step();
    checks++;
    if (obs_a() !== 21'h0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0", obs_a());
    end
    rst_n = 1'b1;
    step();
    test_one_shot();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_a.i_start = 1'b0; bus_a.i_stop = 1'b0; bus_a.i_clear = 1'b0;
    bus_a.i_target = '0;  bus_a.i_auto_reload = 1'b0;
    bus_b.i_start = 1'b0; bus_b.i_stop = 1'b0; bus_b.i_clear = 1'b0;
    bus_b.i_target = '0;  bus_b.i_auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause_resume();
    test_priority();
    test_free_run_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_timer_ctrl.md
# voice_timer_ctrl

Tick-based interval timer controller for the voice path. It divides `clk` down to a tick with a prescaler and sequences a 16-bit tick counter through start, pause, resume, clear and expiry. Expiry runs in one-shot or auto-reload mode. Voice framing and timeout logic use it to schedule periodic events and watchdog intervals from a single command interface.

## Interface
Parameters:
- `PRESCALE`, default `16'd1000`: clk cycles per tick. Legal range 2..65535.
- `CNT_W`, default `16`: tick counter / target width.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  single-cycle command pulse.
  - In IDLE/DONE: clear count, load target, enter RUN.
  - In PAUSE: resume without clearing.
- `i_stop`  in  1  command pulse.
  - RUN→PAUSE.
  - PAUSE→IDLE (abort).
- `i_clear`  in  1  command pulse: any state→IDLE, count cleared.
- `i_target`  in  CNT_W  expiry value, sampled only on start from IDLE/DONE. 0 = never expire (free-run).
- `i_auto_reload`  in  1  sampled with `i_target`. 1 = reload to 0 on expiry and stay in RUN.
- `o_count`  out  CNT_W  current tick count.
- `o_tick`  out  1  one-cycle pulse, coincident with each `o_count` increment.
- `o_expire`  out  1  one-cycle pulse on reaching target.
- `o_busy`  out  1  high in RUN.
- `o_state`  out  2  encoded FSM state.

## Operation
- FSM encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority within one cycle: `i_clear` > `i_stop` > `i_start`. Lower-priority commands in the same cycle are ignored.
- Commands not listed for the current state are ignored:
  - `i_stop` in IDLE/DONE.
  - `i_start` in RUN.
- Prescaler counts 0..PRESCALE-1, advancing only in RUN.
  - Held in PAUSE.
  - Cleared on entering RUN from IDLE/DONE and on entering IDLE.
  - Not cleared on resume from PAUSE.
- Tick condition: RUN and prescaler == PRESCALE-1, with no `i_stop`/`i_clear` that cycle. On a tick:
  - Prescaler wraps to 0.
  - `o_tick` is registered high for one cycle.
- Count update on a tick (target T ≠ 0):
  - If count == T-1 and not auto-reload: count←T, `o_expire`←1, state←DONE.
  - If count == T-1 and auto-reload: count←0, `o_expire`←1, state stays RUN.
  - Otherwise: count←count+1.
- T == 0: count wraps 0xFFFF→0x0000 with no expire.
- A cycle with `i_stop` in RUN discards that cycle's tick: state→PAUSE, prescaler and count hold, no `o_tick`/`o_expire`.
- DONE holds count at T until `i_start` or `i_clear`.
- Arithmetic is unsigned, modulo 2^CNT_W.

## Timing
- Reset value of every output is zero: `o_count`, `o_tick`, `o_expire`, `o_busy`, `o_state`. Prescaler and latched target/mode also reset to zero. Asserting `i_rst_n` low mid-operation forces all of these immediately, independent of `clk`.
- All outputs are registered. No combinational input→output path.
- Start latency: `i_start` sampled at edge of cycle N gives `o_busy`=1 and `o_state`=RUN in cycle N+1.
- First `o_tick`, together with `o_count`=1, appears in cycle N+PRESCALE+1. Subsequent ticks follow every PRESCALE RUN cycles.
- `o_expire` is in the same cycle as the final `o_tick`. `o_state` reads DONE (one-shot) and `o_busy` falls in that same cycle.
- `i_stop`/`i_clear` take effect on the next cycle's outputs.
- Pause preserves phase: total RUN cycles between ticks is always PRESCALE.

## Structure
- Package `voice_timer_pkg`: state enum, `CNT_W` default, `PRESCALE` minimum constant.
- Sub-module `voice_tick_prescaler` (enable, clear, tick-out).
- FSM, command decode and count update stay in the top module.

## Test plan
All scenarios use PRESCALE=4, with `i_start` at cycle 0.
- **One-shot.** `i_target`=3.
  - `o_tick` at cycles 5/9/13, with `o_count` 1/2/3.
  - `o_expire` and `o_state`=DONE at 13, `o_busy`=0 at 13.
- **Auto-reload.** `i_target`=2.
  - `o_count` 1,0,1,0 at cycles 5,9,13,17.
  - `o_expire` at 9 and 17; `o_state` remains RUN.
- **Pause/resume.** `i_target`=5; `i_stop` at cycle 6 → PAUSE, `o_count`=1 held.
  - `i_start` at cycle 20: next `o_tick` at cycle 24 (3 remaining RUN cycles), `o_count`=2.
- **Priority.** `i_clear`+`i_start` in the same cycle → IDLE, count 0.
  - `i_stop` on the expiring tick cycle (count=T-1) → PAUSE, count stays T-1, no `o_expire`.
- **Free-run wrap.** `i_target`=0, PRESCALE=2.
  - After 65536 ticks `o_count` goes 0xFFFF→0x0000 with no `o_expire`.
- **Reset mid-RUN.** `i_rst_n` low at cycle 10 → all outputs 0 immediately.
  - After release, `i_start` reproduces the one-shot timing.
